// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared types and helpers for the pipeline stall controller
package hazard_stall_controller_pkg;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } sb_entry_t;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  function automatic logic src_hit(sb_entry_t e, logic [REG_ADDR_W-1:0] s1, logic [REG_ADDR_W-1:0] s2, logic use2);
    return e.valid && ((s1 != '0 && e.dest == s1) || (use2 && s2 != '0 && e.dest == s2));
  endfunction
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID/branch/memory sequencing signals between the pipeline and the stall controller
interface hazard_stall_controller_if import hazard_stall_controller_pkg::*; #(parameter int STALL_CNT_W = 16);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_src1;
  logic [REG_ADDR_W-1:0]  id_src2;
  logic                   id_single_src;
  logic                   id_mem_w_en;
  logic [REG_ADDR_W-1:0]  id_dest;
  logic                   id_wb_en;
  logic                   id_mem_r_en;
  logic                   br_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   hazard_detected;
  logic                   pc_freeze;
  logic                   if_id_freeze;
  logic                   if_flush;
  logic                   pipe_freeze;
  logic                   mem_error;
  logic [STALL_CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_src1, id_src2, id_single_src, id_mem_w_en, id_dest, id_wb_en, id_mem_r_en,
    output br_taken, mem_req, mem_ready,
    input  hazard_detected, pc_freeze, if_id_freeze, if_flush, pipe_freeze, mem_error, stall_count
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_single_src, id_mem_w_en, id_dest, id_wb_en, id_mem_r_en,
    input  br_taken, mem_req, mem_ready,
    output hazard_detected, pc_freeze, if_id_freeze, if_flush, pipe_freeze, mem_error, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller_mem_wait_fsm.sv
// hazard_stall_controller_mem_wait_fsm: SRAM handshake wait tracking, pipeline freeze and sticky timeout flag
module hazard_stall_controller_mem_wait_fsm import hazard_stall_controller_pkg::*; #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic pipe_freeze,
  output logic mem_error
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  mem_state_t state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic stall;
  // Wait count: first pending cycle counts as 1, then saturates at the timeout
  always_comb begin
    stall = mem_req && !mem_ready;
    pipe_freeze = stall && !rst;
    cnt_nxt = !stall ? '0 : state == IDLE ? CW'(1) : cnt == CW'(MEM_TIMEOUT) ? cnt : cnt + 1'b1;
  end
  // State, counter and sticky error update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= stall ? WAIT : IDLE;
      cnt <= cnt_nxt;
      mem_error <= mem_error || cnt_nxt == CW'(MEM_TIMEOUT);
    end
  end
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: EXE/MEM scoreboard hazard detection, branch flush and memory freeze (FORWARDING_EN: stall on load-use only)
module hazard_stall_controller import hazard_stall_controller_pkg::*; #(
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_stall_controller_if.slave bus
);
  sb_entry_t exe, mem;
  logic use2, hz, hd, fl, pf;
  logic [STALL_CNT_W-1:0] cnt;
  logic unused_sb;
  hazard_stall_controller_mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk(clk),
    .rst(rst),
    .mem_req(bus.mem_req),
    .mem_ready(bus.mem_ready),
    .pipe_freeze(pf),
    .mem_error(bus.mem_error)
  );
  // Hazard term and freeze/flush priority; a taken branch overrides the PC hold
  always_comb begin
    use2 = !bus.id_single_src || bus.id_mem_w_en;
`ifdef FORWARDING_EN
    hz = bus.id_valid && exe.mem_r_en && src_hit(exe, bus.id_src1, bus.id_src2, use2);
`else
    hz = bus.id_valid && ((exe.wb_en && src_hit(exe, bus.id_src1, bus.id_src2, use2)) ||
                          (mem.wb_en && src_hit(mem, bus.id_src1, bus.id_src2, use2)));
`endif
    hd = hz && !pf && !rst;
    fl = bus.br_taken && !pf && !rst;
    bus.hazard_detected = hd;
    bus.if_flush = fl;
    bus.pc_freeze = hd && !fl;
    bus.if_id_freeze = hd && !fl;
    bus.pipe_freeze = pf;
    bus.stall_count = cnt;
  end
  assign unused_sb = ^mem;
  // Scoreboard advances only when the pipeline moves; bubbles on hazard or taken branch
  always_ff @(posedge clk) begin
    if (rst) begin
      exe <= '0;
      mem <= '0;
    end else if (!pf) begin
      mem <= exe;
      exe <= (bus.id_valid && !hd && !bus.br_taken) ?
             sb_entry_t'{valid: 1'b1, dest: bus.id_dest, wb_en: bus.id_wb_en, mem_r_en: bus.id_mem_r_en} : '0;
    end
  end
  // Saturating hazard stall counter
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (hd && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central pipeline sequencing block for the 5-stage MIPS core.
- Tracks in-flight destination registers of the EXE and MEM stages in a 2-entry scoreboard and raises hazard_detected toward the ID stage.
- Owns PC/IF-ID freeze, IF flush on taken branch, and whole-pipeline freeze while the data-memory (SRAM) handshake is pending, including timeout detection.

Parameters:
MEM_TIMEOUT, 64, max consecutive wait cycles on one memory access before mem_error is set
STALL_CNT_W, 16, width of the saturating stall performance counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_src1  input  5  ID source register 1
id_src2  input  5  ID source register 2
id_single_src  input  1  instruction reads src1 only
id_mem_w_en  input  1  store in ID; src2 is read regardless of id_single_src
id_dest  input  5  ID destination register
id_wb_en  input  1  ID instruction writes the register file
id_mem_r_en  input  1  ID instruction is a load
br_taken  input  1  EXE resolved a taken branch
mem_req  input  1  MEM stage requests an SRAM access
mem_ready  input  1  SRAM completes the access this cycle
hazard_detected  output  1  to ID; zeroes control bits (bubble)
pc_freeze  output  1  hold PC
if_id_freeze  output  1  hold IF/ID register
if_flush  output  1  clear IF/ID register
pipe_freeze  output  1  hold all pipeline registers
mem_error  output  1  sticky timeout flag
stall_count  output  STALL_CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (synchronous): scoreboard slots invalid, FSM in IDLE, wait counter 0, mem_error 0, stall_count 0. All outputs 0 in the reset cycle except stall_count (0) and mem_error (0).
- Scoreboard slot fields: valid, dest, wb_en, mem_r_en. Slots are EXE and MEM.
- Register-file writes complete within the WB cycle. WB is never a hazard source.
- A source is considered only if it is nonzero; register 0 never hazards.
- src2 is considered when !id_single_src || id_mem_w_en.
- Hazard, no forwarding: id_valid && a considered source equals dest of a valid slot with wb_en=1.
- hazard_detected, pc_freeze and if_id_freeze are combinational and equal to that hazard term when pipe_freeze=0. All three are forced 0 while pipe_freeze=1.
- Branch: if_flush = br_taken && !pipe_freeze. When if_flush and hazard are both 1, the flush wins: pc_freeze=0 and if_id_freeze=0, while hazard_detected still bubbles the instruction.
- Scoreboard update on each clock with pipe_freeze=0:
  - MEM slot takes the EXE slot.
  - EXE slot takes the ID fields when id_valid && !hazard_detected && !br_taken; otherwise it becomes invalid (bubble).
- With pipe_freeze=1 the scoreboard holds.
- Memory FSM:
  - IDLE: mem_req && !mem_ready moves to WAIT, wait counter = 1. mem_req && mem_ready is a single-cycle access and stays in IDLE.
  - WAIT: mem_ready moves to IDLE and clears the counter. Otherwise the counter increments, saturating at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_error, which stays set until reset; the FSM remains in WAIT.
  - mem_req dropping in WAIT returns to IDLE.
- pipe_freeze = mem_req && !mem_ready (combinational) in either state.
- stall_count increments on every cycle with hazard_detected=1 and saturates at all-ones.
- Reset mid-WAIT: returns to IDLE the next edge. mem_error is cleared.

Optional Feature:
FORWARDING_EN
- Defined: a forwarding unit resolves ALU results. Only a load-use case stalls: a valid EXE slot with mem_r_en=1 whose dest matches a considered nonzero source. MEM-slot matches never stall.
- Undefined: full stall rule as above.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5
  - the scoreboard entry struct {valid, dest, wb_en, mem_r_en}
  - the memory FSM state enum {IDLE, WAIT}
- One natural sub-module: mem_wait_fsm (FSM, wait counter, mem_error, pipe_freeze). Hazard comparison and scoreboard stay in the top.

Test Plan:
- RAW from EXE: issue add r3 (dest 3, wb_en=1), next cycle ID src1=3 -> hazard_detected=1, pc_freeze=1 for 2 cycles (EXE, then MEM slot), stall_count=2. With FORWARDING_EN: 0 stall cycles.
- Load-use with FORWARDING_EN: load dest 5, next ID src2=5, id_single_src=0 -> exactly 1 stall cycle. Same case with id_single_src=1, id_mem_w_en=0 -> 0 stalls.
- Register 0: previous instruction dest 0, wb_en=1; ID src1=0 -> no hazard.
- Branch vs hazard: br_taken=1 coincident with a hazard -> if_flush=1, pc_freeze=0, hazard_detected=1; EXE slot invalid next cycle.
- Memory wait: mem_req=1, mem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, scoreboard unchanged, no flush even with br_taken=1. Flush is issued on the release cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held low -> mem_error=1 after 4 wait cycles, stays 1 after mem_ready. Assert rst -> mem_error=0, FSM IDLE next edge.
